// File: rtl/fib_seq_engine_pkg.sv
// ----------------------------------------------------------------------------
// fib_pkg
// Shared types and default sizes for the Fibonacci sequence engine.
//   fib_state_e : engine control states
//   FIB_DATA_W  : default term width
//   FIB_IDX_W   : default index width (max index 2**FIB_IDX_W-1)
// ----------------------------------------------------------------------------
package fib_pkg;

   localparam int FIB_DATA_W = 16;
   localparam int FIB_IDX_W  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } fib_state_e;

endpackage : fib_pkg

// File: rtl/fib_seq_engine_if.sv
// ----------------------------------------------------------------------------
// fib_seq_engine_if
// Bundles the host control (go/n_in/mode/busy/done/overflow) and the output
// stream (out_valid/out_ready/fib_out/out_idx) of the Fibonacci engine.
//   master : host / consumer side (drives go, n_in, mode, mod_in, out_ready)
//   slave  : engine side (drives out_valid, fib_out, out_idx, busy, done,
//            overflow)
// Build option FIB_MOD_EN adds the modulus input mod_in.
// ----------------------------------------------------------------------------
interface fib_seq_engine_if
   import fib_pkg::*;
#(
   parameter int DATA_W = FIB_DATA_W,
   parameter int IDX_W  = FIB_IDX_W
);

   logic              go;
   logic [IDX_W-1:0]  n_in;
   logic              mode;
`ifdef FIB_MOD_EN
   logic [DATA_W-1:0] mod_in;
`endif
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] fib_out;
   logic [IDX_W-1:0]  out_idx;
   logic              busy;
   logic              done;
   logic              overflow;

`ifdef FIB_MOD_EN
   modport master (
      output go, n_in, mode, mod_in, out_ready,
      input  out_valid, fib_out, out_idx, busy, done, overflow
   );
   modport slave (
      input  go, n_in, mode, mod_in, out_ready,
      output out_valid, fib_out, out_idx, busy, done, overflow
   );
`else
   modport master (
      output go, n_in, mode, out_ready,
      input  out_valid, fib_out, out_idx, busy, done, overflow
   );
   modport slave (
      input  go, n_in, mode, out_ready,
      output out_valid, fib_out, out_idx, busy, done, overflow
   );
`endif

endinterface : fib_seq_engine_if

// File: rtl/fib_seq_engine_step_add.sv
// ----------------------------------------------------------------------------
// fib_step_add
// Combinational next-term adder: sum = a + b, optionally reduced modulo m.
//   a, b   : current terms (both < m when m != 0)
//   m      : modulus; 0 means plain wrap at 2**DATA_W
//   sum    : next term
//   carry  : sum exceeded 2**DATA_W-1 (only meaningful when m == 0)
// ----------------------------------------------------------------------------
module fib_step_add #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] m,
   output logic [DATA_W-1:0] sum,
   output logic              carry
);

   logic [DATA_W:0] full;

   assign full = {1'b0, a} + {1'b0, b};

   always_comb begin
      sum   = full[DATA_W-1:0];
      carry = full[DATA_W];
      if (m != '0) begin
         carry = 1'b0;
         // a,b < m so one subtraction suffices; the low bits alone give the
         // right result because the true difference is below 2**DATA_W.
         if (full >= {1'b0, m})
            sum = full[DATA_W-1:0] - m;
      end
   end

endmodule : fib_step_add

// File: rtl/fib_seq_engine.sv
// ----------------------------------------------------------------------------
// fib_seq_engine
// Computes F(0..n) for a runtime index n. Final mode (mode=0) emits only F(n);
// stream mode (mode=1) emits every term F(0)..F(n) on a valid/ready stream.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : fib_seq_engine_if.slave (go/n_in/mode[/mod_in]/out_ready in;
//           out_valid/fib_out/out_idx/busy/done/overflow out)
// Build option FIB_MOD_EN: terms are reduced modulo mod_in (captured on go);
// a zero modulus falls back to plain wrap with overflow detection.
// ----------------------------------------------------------------------------
module fib_seq_engine
   import fib_pkg::*;
#(
   parameter int DATA_W = FIB_DATA_W,
   parameter int IDX_W  = FIB_IDX_W
) (
   input  logic clk,
   input  logic reset,
   fib_seq_engine_if.slave bus
);

   fib_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, b_q;
   logic [IDX_W-1:0]  k_q, n_q;
   logic              mode_q;
   logic              busy_q;
   logic              ovf_q;
   logic              accept_go;
   logic              advance;
   logic [DATA_W-1:0] mod_use;
   logic [DATA_W-1:0] b_init;
   logic [DATA_W-1:0] sum;
   logic              carry;

`ifdef FIB_MOD_EN
   logic [DATA_W-1:0] mod_q;
   assign mod_use = mod_q;
   // F(1) mod 1 is 0, otherwise 1
   assign b_init  = (bus.mod_in == DATA_W'(1)) ? '0 : DATA_W'(1);
`else
   assign mod_use = '0;
   assign b_init  = DATA_W'(1);
`endif

   fib_step_add #(.DATA_W(DATA_W)) u_step_add (
      .a     (a_q),
      .b     (b_q),
      .m     (mod_use),
      .sum   (sum),
      .carry (carry)
   );

   assign accept_go = (state_q == IDLE) && bus.go;

   always_comb begin
      state_d = state_q;
      advance = 1'b0;
      case (state_q)
         IDLE: if (bus.go) state_d = RUN;
         RUN: begin
            if (!mode_q) begin
               if (k_q == n_q) state_d = EMIT;
               else            advance = 1'b1;
            end else if (bus.out_ready) begin
               // stream mode only moves on a completed handshake
               if (k_q == n_q) state_d = DONE;
               else            advance = 1'b1;
            end
         end
         EMIT: if (bus.out_ready) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         n_q     <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef FIB_MOD_EN
         mod_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept_go) begin
            a_q    <= '0;
            b_q    <= b_init;
            k_q    <= '0;
            n_q    <= bus.n_in;
            mode_q <= bus.mode;
            busy_q <= 1'b1;
            ovf_q  <= 1'b0;
`ifdef FIB_MOD_EN
            mod_q  <= bus.mod_in;
`endif
         end else if (advance) begin
            a_q <= b_q;
            b_q <= sum;
            k_q <= k_q + 1'b1;
            // b is one term ahead, so this also flags F(n+1)
            if (carry) ovf_q <= 1'b1;
         end
         if (state_q == DONE) busy_q <= 1'b0;
      end
   end

   // In final mode k equals n_q while in EMIT, so k serves as the index.
   assign bus.out_valid = (state_q == EMIT) || ((state_q == RUN) && mode_q);
   assign bus.fib_out   = a_q;
   assign bus.out_idx   = k_q;
   assign bus.busy      = busy_q;
   assign bus.done      = (state_q == DONE);
   assign bus.overflow  = ovf_q;

endmodule : fib_seq_engine

// File: tb/tb_fib_seq_engine.sv
// ----------------------------------------------------------------------------
// tb_fib_seq_engine
// Randomised and directed bench for fib_seq_engine with a behavioural
// Fibonacci reference (exact integers, reduced afterwards).
// Honours FIB_MOD_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_fib_seq_engine;

   localparam int DW = 16;
   localparam int IW = 5;
   localparam int MAXN = (1 << IW) - 1;

   logic clk;
   logic reset;

   int n_checks;
   int n_fails;

   longint exp_val [0:MAXN];
   logic   exp_ov;

   fib_seq_engine_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

   fib_seq_engine #(.DATA_W(DW), .IDX_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: exact Fibonacci numbers, reduced mod M (M>0) or mod 2**DW.
   task automatic build_model(input int n, input longint m);
      longint f [0:MAXN+1];
      f[0] = 0;
      f[1] = 1;
      for (int i = 2; i <= MAXN + 1; i++) f[i] = f[i-1] + f[i-2];
      for (int i = 0; i <= MAXN; i++)
         exp_val[i] = (m > 0) ? (f[i] % m) : (f[i] % (longint'(1) << DW));
      exp_ov = (m == 0) && (n >= 1) && (f[n+1] >= (longint'(1) << DW));
   endtask

   task automatic run_job(input int n, input int md, input longint m,
                          input int ready_pct, input bit poke_go);
      int     beat;
      int     done_cnt;
      int     cyc;
      bit     fin;
      bit     stall;
      longint prev_val;
      longint prev_idx;
      bit     r;
      build_model(n, m);
      bus.go   = 1'b1;
      bus.n_in = IW'(n);
      bus.mode = md[0];
`ifdef FIB_MOD_EN
      bus.mod_in = DW'(m);
`endif
      @(posedge clk); #1;
      bus.go   = 1'b0;
      bus.n_in = IW'($urandom);
      bus.mode = $urandom_range(1);
      check("busy_after_go", bus.busy, 1);
      beat = 0; done_cnt = 0; cyc = 0; fin = 0; stall = 0;
      prev_val = 0; prev_idx = 0;
      while (!fin && cyc < 600) begin
         bus.go = poke_go && (cyc == 2);
         if (poke_go && cyc == 2) begin
            bus.n_in = IW'(3);
            bus.mode = ~md[0];
         end
         if (stall) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_val", bus.fib_out, prev_val);
            check("stall_idx", bus.out_idx, prev_idx);
         end
         if (bus.done) begin
            done_cnt++;
            fin = 1;
            check("done_no_valid", bus.out_valid, 0);
         end
         r = ($urandom_range(99) < ready_pct);
         bus.out_ready = r;
         if (bus.out_valid && r) begin
            if (md == 0) begin
               check("final_idx", bus.out_idx, n);
               check("final_val", bus.fib_out, exp_val[n]);
            end else if (beat <= n) begin
               check("beat_idx", bus.out_idx, beat);
               check("beat_val", bus.fib_out, exp_val[beat]);
            end
            beat++;
         end
         stall    = bus.out_valid && !r;
         prev_val = bus.fib_out;
         prev_idx = bus.out_idx;
         @(posedge clk); #1;
         cyc++;
      end
      bus.go = 1'b0;
      if (!fin) check("timeout", 0, 1);
      check("done_pulses", done_cnt, 1);
      check("beat_count", beat, (md == 0) ? 1 : n + 1);
      check("overflow", bus.overflow, exp_ov);
      check("busy_idle", bus.busy, 0);
      check("done_one_cycle", bus.done, 0);
      check("valid_idle", bus.out_valid, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset = 1'b0;
      bus.go = 1'b0;
      bus.n_in = '0;
      bus.mode = 1'b0;
      bus.out_ready = 1'b0;
`ifdef FIB_MOD_EN
      bus.mod_in = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", bus.out_valid, 0);
      check("rst_fib", bus.fib_out, 0);
      check("rst_idx", bus.out_idx, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ovf", bus.overflow, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // directed cases
      run_job(10, 0, 0, 100, 0);
      run_job(24, 0, 0, 100, 0);
      run_job(25, 0, 0, 100, 0);
      run_job(5, 1, 0, 50, 0);
      run_job(0, 0, 0, 100, 0);
      run_job(0, 1, 0, 40, 0);
      run_job(MAXN, 1, 0, 100, 0);
      run_job(MAXN, 0, 0, 60, 0);
      // go while busy must not disturb the job in flight
      run_job(20, 0, 0, 100, 1);
      run_job(12, 1, 0, 70, 1);
`ifdef FIB_MOD_EN
      run_job(10, 0, 7, 100, 0);
      run_job(0, 1, 7, 100, 0);
      run_job(15, 1, 1, 60, 0);
      run_job(MAXN, 1, 1000, 80, 0);
`endif

      // randomised jobs
      for (int j = 0; j < 14; j++) begin
`ifdef FIB_MOD_EN
         run_job($urandom_range(MAXN), $urandom_range(1),
                 ($urandom_range(3) == 0) ? 0 : longint'($urandom_range(65535)),
                 $urandom_range(100, 30), 0);
`else
         run_job($urandom_range(MAXN), $urandom_range(1), 0,
                 $urandom_range(100, 30), 0);
`endif
      end

      // reset in the middle of a run: aborts at once, no done pulse
      bus.go   = 1'b1;
      bus.n_in = IW'(30);
      bus.mode = 1'b0;
`ifdef FIB_MOD_EN
      bus.mod_in = '0;
`endif
      @(posedge clk); #1;
      bus.go = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("pre_abort_busy", bus.busy, 1);
      check("pre_abort_fib", bus.fib_out, 8);
      #2;
      reset = 1'b0;
      #1;
      check("abort_valid", bus.out_valid, 0);
      check("abort_fib", bus.fib_out, 0);
      check("abort_idx", bus.out_idx, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      @(posedge clk); #1;
      check("abort_fib_edge", bus.fib_out, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", bus.done, 0);
         check("abort_stays_idle", bus.busy, 0);
      end

      // engine usable again afterwards
      run_job(7, 1, 0, 100, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_fib_seq_engine
